// File: rtl/isa_dispatch_pkg.sv
// ============================================================================
// Module      : isa_dispatch_pkg
// Description : Shared types and constants for the instruction dispatcher.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package isa_dispatch_pkg;

    localparam int unsigned c_ip_w    = 64;
    localparam int unsigned c_instr_w = 16;
    localparam int unsigned c_fld_w   = 4;

    // Bit positions of the instruction fields
    localparam int unsigned c_opc_lsb = 12;
    localparam int unsigned c_r0_lsb  = 8;
    localparam int unsigned c_r1_lsb  = 4;
    localparam int unsigned c_r2_lsb  = 0;

    // Opcode of each execution unit (opcode == unit index)
    localparam logic [3:0] BRC_EQ  = 4'd0;
    localparam logic [3:0] BRC_NE  = 4'd1;
    localparam logic [3:0] BRC_LT  = 4'd2;
    localparam logic [3:0] BRC_GE  = 4'd3;
    localparam logic [3:0] ALU_ADD = 4'd4;
    localparam logic [3:0] ALU_SUB = 4'd5;
    localparam logic [3:0] ALU_LOG = 4'd6;
    localparam logic [3:0] ALU_SHF = 4'd7;
    localparam logic [3:0] MEM_LD  = 4'd8;
    localparam logic [3:0] MEM_ST  = 4'd9;
    localparam logic [3:0] MUL_OP  = 4'd10;
    localparam logic [3:0] DIV_OP  = 4'd11;
    localparam logic [3:0] SYS_CAL = 4'd12;
    localparam logic [3:0] SYS_CSR = 4'd13;
    localparam logic [3:0] FPU_OP  = 4'd14;
    localparam logic [3:0] EXT_OP  = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DECODE  = 3'd1,
        S_EXEC    = 3'd2,
        S_RELEASE = 3'd3,
        S_COMMIT  = 3'd4
    } state_t;

    function automatic logic [c_fld_w-1:0] get_field(
        input logic [c_instr_w-1:0] word,
        input int unsigned          lsb
    );
        return word[lsb +: c_fld_w];
    endfunction

endpackage

`default_nettype wire

// File: rtl/isa_dispatch_wdog.sv
// ============================================================================
// Module      : isa_dispatch_wdog
// Description : EXEC-phase watchdog: counts EXEC cycles, flags the last one.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module isa_dispatch_wdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic expired
);

    localparam int unsigned     c_cnt_w = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TIMEOUT - 1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (run && (r_cnt != c_last)) begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

    // Fires during the TIMEOUT-th EXEC cycle so the exit edge ends EXEC on time
    assign expired = run && (r_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/isa_dispatch.sv
// ============================================================================
// Module      : isa_dispatch
// Description : Instruction dispatcher: decode, enable one unit, commit ip.
//               Optional watchdog build macro: ISA_DISPATCH_TIMEOUT_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module isa_dispatch
    import isa_dispatch_pkg::*;
#(
    parameter int unsigned NUNITS  = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 instr_valid,
    input  logic [15:0]          instr,
    output logic                 instr_ready,
    output logic [NUNITS-1:0]    unit_en,
    output logic [3:0]           r0,
    output logic [3:0]           r1,
    output logic [3:0]           r2,
    input  logic [NUNITS-1:0]    unit_finished,
    input  logic                 unit_ip_set,
    input  logic [c_ip_w-1:0]    unit_ip_val,
    output logic [c_ip_w-1:0]    ip,
    output logic                 busy,
    output logic                 illegal,
    output logic                 fault
);

    state_t              r_state;
    state_t              w_next;
    logic [3:0]          r_opcode;
    logic [3:0]          r_r0;
    logic [3:0]          r_r1;
    logic [3:0]          r_r2;
    logic [c_ip_w-1:0]   r_ip;
    logic [c_ip_w-1:0]   r_target;
    logic                r_taken;
    logic                r_fault;
    logic                w_legal;
    logic                w_finished;
    logic                w_expired;

    if ((NUNITS < 1) || (NUNITS > 16) || (TIMEOUT < 1)) begin : g_bad_params
        // Unsupported configuration; left empty so lint flags the unused block
    end

`ifdef ISA_DISPATCH_TIMEOUT_EN
    isa_dispatch_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (r_state == S_DECODE),
        .run     (r_state == S_EXEC),
        .expired (w_expired)
    );
`else
    assign w_expired = 1'b0;
`endif

    assign w_legal = (32'(r_opcode) < NUNITS);

    // Enable is decoded from state so any reset drops it in the same time step
    always_comb begin
        unit_en    = '0;
        w_finished = 1'b0;
        for (int i = 0; i < int'(NUNITS); i++) begin
            if (r_opcode == 4'(i)) begin
                unit_en[i] = (r_state == S_EXEC);
                w_finished = unit_finished[i];
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (instr_valid) w_next = S_DECODE;
            S_DECODE:  w_next = w_legal ? S_EXEC : S_COMMIT;
            S_EXEC:    if (w_finished || w_expired) w_next = S_RELEASE;
            S_RELEASE: w_next = S_COMMIT;
            S_COMMIT:  w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_opcode <= '0;
            r_r0     <= '0;
            r_r1     <= '0;
            r_r2     <= '0;
            r_ip     <= '0;
            r_target <= '0;
            r_taken  <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (instr_valid) begin
                        r_opcode <= get_field(instr, c_opc_lsb);
                        r_r0     <= get_field(instr, c_r0_lsb);
                        r_r1     <= get_field(instr, c_r1_lsb);
                        r_r2     <= get_field(instr, c_r2_lsb);
                    end
                end
                S_DECODE: r_taken <= 1'b0;
                S_EXEC: begin
                    // A timeout abandons any captured branch target
                    if (w_expired && !w_finished) begin
                        r_taken <= 1'b0;
                        r_fault <= 1'b1;
                    end else if (unit_ip_set) begin
                        r_target <= unit_ip_val;
                        r_taken  <= 1'b1;
                    end
                end
                S_COMMIT: r_ip <= r_taken ? r_target : (r_ip + c_ip_w'(1));
                default: ;
            endcase
        end
    end

    assign instr_ready = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign illegal     = (r_state == S_DECODE) && !w_legal;
    assign fault       = r_fault;
    assign r0          = r_r0;
    assign r1          = r_r1;
    assign r2          = r_r2;
    assign ip          = r_ip;

endmodule

`default_nettype wire

// File: doc/isa_dispatch.md
ISA_DISPATCH -- requirements
Module: isa_dispatch

Interface
REQ-001 Parameter NUNITS, default 8: number of instruction execution units; 1..16.
REQ-002 Parameter TIMEOUT, default 255: watchdog limit in cycles; used only when ISA_DISPATCH_TIMEOUT_EN is defined.
REQ-003 clk  in  1  single clock; all state changes on posedge clk.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 instr_valid  in  1  instruction word is present on instr.
REQ-006 instr  in  16  instruction word: [15:12] opcode, [11:8] r0, [7:4] r1, [3:0] r2.
REQ-007 instr_ready  out  1  dispatcher accepts instr this cycle.
REQ-008 unit_en  out  NUNITS  one-hot level enable to execution units.
REQ-009 r0, r1, r2  out  4 each  latched operand fields, stable while any unit_en bit is high.
REQ-010 unit_finished  in  NUNITS  per-unit finished level.
REQ-011 unit_ip_set  in  1  OR of unit ip_set strobes.
REQ-012 unit_ip_val  in  64  muxed ip_val of the enabled unit.
REQ-013 ip  out  64  architectural instruction pointer.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 illegal  out  1  one-cycle pulse on undefined opcode.
REQ-016 fault  out  1  sticky watchdog flag; tied 0 without ISA_DISPATCH_TIMEOUT_EN.

Function
REQ-017 States: IDLE, DECODE, EXEC, RELEASE, COMMIT.
REQ-018 IDLE: instr_ready=1; on instr_valid, latch opcode/r0/r1/r2, go to DECODE.
REQ-019 DECODE: opcode<NUNITS -> set unit_en[opcode], clear branch-taken flag, go to EXEC; else pulse illegal, go to COMMIT without enabling any unit.
REQ-020 EXEC: hold unit_en; if unit_ip_set=1 in any cycle, capture unit_ip_val and set branch-taken; last capture wins.
REQ-021 EXEC: when unit_finished[opcode]=1, clear unit_en, go to RELEASE; unit_finished bits of other units are ignored.
REQ-022 RELEASE: unit_en all zero for exactly one cycle so the unit sees the enable falling edge and resets; go to COMMIT.
REQ-023 COMMIT: ip <= captured value if branch-taken, else ip+1 (64-bit, wraps 2^64-1 -> 0); go to IDLE.
REQ-024 Minimum instruction period: accept->next accept = 4 cycles + EXEC length; illegal instruction = 3 cycles.
REQ-025 unit_ip_set and unit_finished asserted in the same EXEC cycle: target captured and exit to RELEASE in that same cycle.
REQ-026 instr_valid outside IDLE is ignored; instr_ready=0 there.
REQ-027 unit_en is never multi-hot and never high outside EXEC.

Reset
REQ-028 rst_n low: state=IDLE, ip=0, unit_en=0, r0/r1/r2=0, illegal=0, fault=0, branch-taken=0, watchdog=0, immediately and asynchronously.
REQ-029 Reset mid-EXEC drops unit_en at once; the unit resets on that edge; no ip update occurs.

Configuration
REQ-030 Macro ISA_DISPATCH_TIMEOUT_EN defined: cycle counter cleared on EXEC entry; reaching TIMEOUT in EXEC sets fault, clears unit_en, goes to RELEASE with branch-taken forced 0.
REQ-031 Macro undefined: no counter, EXEC waits indefinitely, fault constant 0.

Structure
REQ-032 Shared package holds state enum, opcode field positions, opcode constants per unit (BRC_EQ, BRC_NE, ...), and IP width 64.
REQ-033 One sub-module isa_dispatch_wdog (counter + compare), instantiated only under ISA_DISPATCH_TIMEOUT_EN; unit output muxing stays outside this block.

Verification
REQ-034 Reset, instr=0x1234 valid, unit 1 finishes 6 cycles after enable with no ip_set -> unit_en=0x02 for 6 cycles, one zero cycle, ip=1.
REQ-035 Unit 2 pulses ip_set with ip_val=0x40 then finishes -> ip=0x40; unit_en low exactly one cycle before COMMIT.
REQ-036 Opcode 0xF, NUNITS=8 -> illegal pulse 1 cycle, unit_en stays 0, ip+1, instr_ready back after 3 cycles.
REQ-037 ip=0xFFFF_FFFF_FFFF_FFFF, non-branch instruction -> ip=0.
REQ-038 rst_n low during EXEC -> unit_en=0 same time step, ip=0; after release first instr accepted normally.
REQ-039 With ISA_DISPATCH_TIMEOUT_EN, TIMEOUT=16, unit never finishes -> fault=1 after 16 EXEC cycles, ip+1, fault stays set until reset.
